// File: rtl/fcp_pkg.sv
// fcp_pkg
// Shared definitions for the FCP master controller: command and ACK codes,
// the CRC-8 polynomial, PHY symbol and response status encodings, the
// controller state type and the byte-serial CRC-8 update function.
package fcp_pkg;

  localparam logic [7:0] CMD_SBRWR = 8'h0B;
  localparam logic [7:0] CMD_SBRRD = 8'h0C;
  localparam logic [7:0] ACK_CODE  = 8'h08;
  localparam logic [7:0] CRC_POLY  = 8'h39;

  // phy_tx_type encodings; BYTE_FIRST makes the PHY prefix a SYNC
  localparam logic [1:0] PHY_PING       = 2'b00;
  localparam logic [1:0] PHY_BYTE_FIRST = 2'b01;
  localparam logic [1:0] PHY_BYTE       = 2'b10;

  // rsp_status encodings
  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_NACK    = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;
  localparam logic [1:0] RSP_CRC_ERR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_PING,
    S_W_SPING,
    S_TX_CMD,
    S_TX_ADDR,
    S_TX_DATA,
    S_TX_CRC,
    S_TX_EPING,
    S_W_RPING,
    S_RX_ACK,
    S_RX_DATA,
    S_RX_CRC,
    S_W_EPING,
    S_GAP
  } fcp_state_e;

  // One byte of CRC-8, MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/fcp_crc8.sv
// fcp_crc8
// Byte-serial CRC-8 accumulator shared by the transmit and receive paths.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   clr_i       - restart the CRC at 0x00 (wins over en_i)
//   en_i        - fold data_i into the running CRC
//   data_i      - byte to accumulate
//   crc_o       - current CRC value
module fcp_crc8
  import fcp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (en_i) begin
      crc_d = crc8_update(crc_q, data_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/fcp_mst_ctrl.sv
// fcp_mst_ctrl
// FCP master transaction controller. Accepts one SBRWR/SBRRD request at a
// time, sends ping/command/address/[data]/CRC/ping symbols to the PHY,
// collects the slave ping/ACK/[data/CRC] response, enforces an idle gap after
// every attempt and retries failed attempts (except NACK).
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   ui_tick                         - one-clk pulse per unit interval
//   req_valid/req_ready             - request handshake (ready only when idle)
//   req_wr, req_addr, req_wdata     - request fields (1 = write)
//   rsp_valid, rsp_rdata, rsp_status- one-clk response pulse with result
//   phy_tx_valid/ready/type/byte    - symbol handshake to the PHY
//   phy_rx_ping/valid/byte/err      - received ping and byte pulses
//   busy                            - transaction in progress
module fcp_mst_ctrl
  import fcp_pkg::*;
#(
  parameter int MAX_RETRY = 2,
  parameter int RSP_TO_UI = 50,
  parameter int GAP_UI    = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ui_tick,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       phy_tx_valid,
  input  logic       phy_tx_ready,
  output logic [1:0] phy_tx_type,
  output logic [7:0] phy_tx_byte,
  input  logic       phy_rx_ping,
  input  logic       phy_rx_valid,
  input  logic [7:0] phy_rx_byte,
  input  logic       phy_rx_err,
  output logic       busy
);

  localparam int CNT_MAX = (RSP_TO_UI > GAP_UI) ? RSP_TO_UI : GAP_UI;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  fcp_state_e       state_q, state_d;
  logic             wr_q, wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [1:0]       attStatus_q, attStatus_d;
  logic [RTY_W-1:0] retryCnt_q, retryCnt_d;
  logic [CNT_W-1:0] uiCnt_q, uiCnt_d;
  logic             rspValid_q, rspValid_d;
  logic [7:0]       rspRdata_q, rspRdata_d;
  logic [1:0]       rspStatus_q, rspStatus_d;

  logic             cntRun;
  logic             crcClr, crcEn;
  logic [7:0]       crcDin, crcVal;
  logic             rspTimeout, gapDone;

  fcp_crc8 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (crcClr),
    .en_i   (crcEn),
    .data_i (crcDin),
    .crc_o  (crcVal)
  );

  // Expiry is qualified by the tick that would make the count reach the limit
  assign rspTimeout = ui_tick && (uiCnt_q == CNT_W'(RSP_TO_UI - 1));
  assign gapDone    = ui_tick && (uiCnt_q == CNT_W'(GAP_UI - 1));

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    attStatus_d  = attStatus_q;
    retryCnt_d   = retryCnt_q;
    rspValid_d   = 1'b0;
    rspRdata_d   = rspRdata_q;
    rspStatus_d  = rspStatus_q;
    cntRun       = 1'b0;
    crcClr       = 1'b0;
    crcEn        = 1'b0;
    crcDin       = 8'h00;
    phy_tx_valid = 1'b0;
    phy_tx_type  = PHY_PING;
    phy_tx_byte  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d        = req_wr;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          attStatus_d = RSP_OK;
          retryCnt_d  = '0;
          state_d     = S_TX_PING;
        end
      end
      S_TX_PING: begin
        crcClr       = 1'b1;
        phy_tx_valid = 1'b1;
        if (phy_tx_ready) state_d = S_W_SPING;
      end
      S_W_SPING: begin
        cntRun = 1'b1;
        // A ping in the expiry clk still counts as the ping
        if (phy_rx_ping) begin
          state_d = S_TX_CMD;
        end else if (rspTimeout) begin
          attStatus_d = RSP_TIMEOUT;
          state_d     = S_GAP;
        end
      end
      S_TX_CMD: begin
        phy_tx_valid = 1'b1;
        phy_tx_type  = PHY_BYTE_FIRST;
        phy_tx_byte  = wr_q ? CMD_SBRWR : CMD_SBRRD;
        crcDin       = phy_tx_byte;
        if (phy_tx_ready) begin
          crcEn   = 1'b1;
          state_d = S_TX_ADDR;
        end
      end
      S_TX_ADDR: begin
        phy_tx_valid = 1'b1;
        phy_tx_type  = PHY_BYTE;
        phy_tx_byte  = addr_q;
        crcDin       = addr_q;
        if (phy_tx_ready) begin
          crcEn   = 1'b1;
          state_d = wr_q ? S_TX_DATA : S_TX_CRC;
        end
      end
      S_TX_DATA: begin
        phy_tx_valid = 1'b1;
        phy_tx_type  = PHY_BYTE;
        phy_tx_byte  = wdata_q;
        crcDin       = wdata_q;
        if (phy_tx_ready) begin
          crcEn   = 1'b1;
          state_d = S_TX_CRC;
        end
      end
      S_TX_CRC: begin
        phy_tx_valid = 1'b1;
        phy_tx_type  = PHY_BYTE;
        phy_tx_byte  = crcVal;
        // Restart the shared CRC so it is ready to check the response
        if (phy_tx_ready) begin
          crcClr  = 1'b1;
          state_d = S_TX_EPING;
        end
      end
      S_TX_EPING: begin
        phy_tx_valid = 1'b1;
        if (phy_tx_ready) state_d = S_W_RPING;
      end
      S_W_RPING: begin
        cntRun = 1'b1;
        if (phy_rx_ping) begin
          state_d = S_RX_ACK;
        end else if (rspTimeout) begin
          attStatus_d = RSP_TIMEOUT;
          state_d     = S_GAP;
        end
      end
      S_RX_ACK: begin
        cntRun = 1'b1;
        crcDin = phy_rx_byte;
        if (phy_rx_valid) begin
          crcEn = 1'b1;
          // A corrupted ACK is a CRC error, not a NACK; the frame still runs on
          if (phy_rx_err) begin
            attStatus_d = RSP_CRC_ERR;
            state_d     = wr_q ? S_W_EPING : S_RX_DATA;
          end else if (phy_rx_byte == ACK_CODE) begin
            state_d = wr_q ? S_W_EPING : S_RX_DATA;
          end else begin
            attStatus_d = RSP_NACK;
            state_d     = S_W_EPING;
          end
        end else if (rspTimeout) begin
          attStatus_d = RSP_TIMEOUT;
          state_d     = S_GAP;
        end
      end
      S_RX_DATA: begin
        cntRun = 1'b1;
        crcDin = phy_rx_byte;
        if (phy_rx_valid) begin
          crcEn   = 1'b1;
          rdata_d = phy_rx_byte;
          if (phy_rx_err) attStatus_d = RSP_CRC_ERR;
          state_d = S_RX_CRC;
        end else if (rspTimeout) begin
          attStatus_d = RSP_TIMEOUT;
          state_d     = S_GAP;
        end
      end
      S_RX_CRC: begin
        cntRun = 1'b1;
        if (phy_rx_valid) begin
          if (phy_rx_err || (phy_rx_byte != crcVal)) attStatus_d = RSP_CRC_ERR;
          state_d = S_W_EPING;
        end else if (rspTimeout) begin
          attStatus_d = RSP_TIMEOUT;
          state_d     = S_GAP;
        end
      end
      S_W_EPING: begin
        cntRun = 1'b1;
        if (phy_rx_ping) begin
          state_d = S_GAP;
        end else if (rspTimeout) begin
          attStatus_d = RSP_TIMEOUT;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        cntRun = 1'b1;
        if (gapDone) begin
          if ((attStatus_q == RSP_OK) || (attStatus_q == RSP_NACK) ||
              (retryCnt_q == RTY_W'(MAX_RETRY))) begin
            rspValid_d  = 1'b1;
            rspStatus_d = attStatus_q;
            rspRdata_d  = ((attStatus_q == RSP_OK) && !wr_q) ? rdata_q : 8'h00;
            state_d     = S_IDLE;
          end else begin
            retryCnt_d  = retryCnt_q + RTY_W'(1);
            attStatus_d = RSP_OK;
            state_d     = S_TX_PING;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every wait/gap step starts its UI count from zero; the count saturates
    if (state_d != state_q) begin
      uiCnt_d = '0;
    end else if (cntRun && ui_tick && (uiCnt_q != CNT_W'(CNT_MAX))) begin
      uiCnt_d = uiCnt_q + CNT_W'(1);
    end else begin
      uiCnt_d = uiCnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      attStatus_q <= RSP_OK;
      retryCnt_q  <= '0;
      uiCnt_q     <= '0;
      rspValid_q  <= 1'b0;
      rspRdata_q  <= 8'h00;
      rspStatus_q <= RSP_OK;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      attStatus_q <= attStatus_d;
      retryCnt_q  <= retryCnt_d;
      uiCnt_q     <= uiCnt_d;
      rspValid_q  <= rspValid_d;
      rspRdata_q  <= rspRdata_d;
      rspStatus_q <= rspStatus_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rspValid_q;
  assign rsp_rdata  = rspRdata_q;
  assign rsp_status = rspStatus_q;

endmodule

// File: tb/tb_fcp_mst_ctrl.sv
// tb_fcp_mst_ctrl
// Directed self-checking bench for fcp_mst_ctrl. Small timeout and gap
// parameters keep the UI-driven sequences short; ui_tick is pulsed by hand
// so tick counts are exact. Inputs are driven and outputs sampled on the
// falling clock edge.
`timescale 1ns/1ps
module tb_fcp_mst_ctrl;

  localparam int MAX_RETRY = 2;
  localparam int RSP_TO_UI = 5;
  localparam int GAP_UI    = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ui_tick;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic       phy_tx_valid;
  logic       phy_tx_ready;
  logic [1:0] phy_tx_type;
  logic [7:0] phy_tx_byte;
  logic       phy_rx_ping;
  logic       phy_rx_valid;
  logic [7:0] phy_rx_byte;
  logic       phy_rx_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  fcp_mst_ctrl #(
    .MAX_RETRY (MAX_RETRY),
    .RSP_TO_UI (RSP_TO_UI),
    .GAP_UI    (GAP_UI)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ui_tick      (ui_tick),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_status   (rsp_status),
    .phy_tx_valid (phy_tx_valid),
    .phy_tx_ready (phy_tx_ready),
    .phy_tx_type  (phy_tx_type),
    .phy_tx_byte  (phy_tx_byte),
    .phy_rx_ping  (phy_rx_ping),
    .phy_rx_valid (phy_rx_valid),
    .phy_rx_byte  (phy_rx_byte),
    .phy_rx_err   (phy_rx_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: all enter and leave on a falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    ui_tick = 1'b1;
    cyc();
    ui_tick = 1'b0;
  endtask

  task automatic send_ping();
    phy_rx_ping = 1'b1;
    cyc();
    phy_rx_ping = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    phy_rx_valid = 1'b1;
    phy_rx_byte  = b;
    phy_rx_err   = err;
    cyc();
    phy_rx_valid = 1'b0;
    phy_rx_err   = 1'b0;
    phy_rx_byte  = 8'h00;
  endtask

  task automatic request(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    cyc();
    // Scramble the fields so a controller that does not latch them is exposed
    req_valid = 1'b0;
    req_wr    = ~wr;
    req_addr  = 8'hFF;
    req_wdata = 8'hFF;
  endtask

  // Waits (bounded) for a symbol, captures it and lets it be consumed
  task automatic get_tx(output bit ok, output logic [1:0] typ, output logic [7:0] byt);
    ok  = 1'b0;
    typ = 2'b11;
    byt = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (phy_tx_valid === 1'b1) begin
        ok  = 1'b1;
        typ = phy_tx_type;
        byt = phy_tx_byte;
        cyc();
        break;
      end
      cyc();
    end
  endtask

  task automatic run_ticks(input int n, output bit sawRsp, output bit sawTx);
    sawRsp = 1'b0;
    sawTx  = 1'b0;
    for (int i = 0; i < n; i++) begin
      pulse_tick();
      if (rsp_valid !== 1'b0) sawRsp = 1'b1;
      if (phy_tx_valid !== 1'b0) sawTx = 1'b1;
    end
  endtask

  // Master side of one attempt: ping, nSym bytes, end ping, slave pings answered
  task automatic master_phase(input int nSym, output bit ok);
    bit g;
    logic [1:0] t;
    logic [7:0] b;
    ok = 1'b1;
    get_tx(g, t, b);
    if (!g || t !== 2'b00) ok = 1'b0;
    send_ping();
    for (int i = 0; i < nSym; i++) begin
      get_tx(g, t, b);
      if (!g) ok = 1'b0;
    end
    get_tx(g, t, b);
    if (!g || t !== 2'b00) ok = 1'b0;
    send_ping();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid, phy_tx_valid} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got ready/busy/rspv/txv=%b expected 1000",
               {req_ready, busy, rsp_valid, phy_tx_valid});
    end
    checks++;
    if ({rsp_status, rsp_rdata, phy_tx_type, phy_tx_byte} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_values: got status=%b rdata=%h type=%b byte=%h expected all zero",
               rsp_status, rsp_rdata, phy_tx_type, phy_tx_byte);
    end
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (req_ready !== 1'b1 || phy_tx_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got ready=%b txv=%b expected ready=1 txv=0",
               req_ready, phy_tx_valid);
    end
  endtask

  task automatic test_write();
    bit ok, sawRsp, sawTx;
    logic [1:0] t;
    logic [7:0] b;
    logic [1:0] expT [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10};
    logic [7:0] expB [5] = '{8'h00, 8'h0B, 8'h2C, 8'h5A, 8'h34};
    request(1'b1, 8'h2C, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      get_tx(ok, t, b);
      checks++;
      if (!ok || t !== expT[i] || b !== expB[i]) begin
        failures++;
        $display("[TB] FAIL write_sym%0d: got ok=%0d type=%b byte=%h expected type=%b byte=%h",
                 i, ok, t, b, expT[i], expB[i]);
      end
      if (i == 0) send_ping();
    end
    get_tx(ok, t, b);
    checks++;
    if (!ok || t !== 2'b00) begin
      failures++;
      $display("[TB] FAIL write_eping: got ok=%0d type=%b expected type=00", ok, t);
    end
    send_ping();
    send_byte(8'h08, 1'b0);
    send_ping();
    run_ticks(GAP_UI - 1, sawRsp, sawTx);
    checks++;
    if (sawRsp || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write_gap: got earlyRsp=%0d busy=%b expected 0 and 1", sawRsp, busy);
    end
    pulse_tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 8'h00) begin
      failures++;
      $display("[TB] FAIL write_rsp: got v=%b status=%b rdata=%h expected v=1 status=00 rdata=00",
               rsp_valid, rsp_status, rsp_rdata);
    end
    cyc();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL write_done: got v=%b busy=%b ready=%b expected 0 0 1",
               rsp_valid, busy, req_ready);
    end
  endtask

  task automatic test_timeout();
    bit ok, sawRsp, sawTx;
    logic [1:0] t;
    logic [7:0] b;
    request(1'b0, 8'h04, 8'h00);
    for (int a = 0; a < 3; a++) begin
      get_tx(ok, t, b);
      checks++;
      if (!ok || t !== 2'b00) begin
        failures++;
        $display("[TB] FAIL timeout_ping%0d: got ok=%0d type=%b expected ping", a, ok, t);
      end
      run_ticks(RSP_TO_UI + GAP_UI - 1, sawRsp, sawTx);
      checks++;
      if (sawRsp || sawTx) begin
        failures++;
        $display("[TB] FAIL timeout_quiet%0d: got rsp=%0d tx=%0d expected 0 0", a, sawRsp, sawTx);
      end
      pulse_tick();
      if (a < 2) begin
        checks++;
        if (phy_tx_valid !== 1'b1 || rsp_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL timeout_retry%0d: got txv=%b rspv=%b expected 1 0",
                   a, phy_tx_valid, rsp_valid);
        end
      end
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_rdata !== 8'h00) begin
      failures++;
      $display("[TB] FAIL timeout_rsp: got v=%b status=%b rdata=%h expected v=1 status=10 rdata=00",
               rsp_valid, rsp_status, rsp_rdata);
    end
    cyc();
    checks++;
    if (phy_tx_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_no_4th: got txv=%b ready=%b expected 0 1", phy_tx_valid, req_ready);
    end
  endtask

  task automatic test_nack_stall();
    bit ok, stable, sawRsp, sawTx;
    logic [1:0] t;
    logic [7:0] b;
    request(1'b1, 8'h10, 8'h77);
    get_tx(ok, t, b);
    send_ping();
    phy_tx_ready = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (phy_tx_valid !== 1'b1 || phy_tx_type !== 2'b01 || phy_tx_byte !== 8'h0B) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("[TB] FAIL stall_stable: got type=%b byte=%h v=%b expected stable 01/0b/1",
               phy_tx_type, phy_tx_byte, phy_tx_valid);
    end
    phy_tx_ready = 1'b1;
    get_tx(ok, t, b);
    get_tx(ok, t, b);
    checks++;
    if (!ok || t !== 2'b10 || b !== 8'h10) begin
      failures++;
      $display("[TB] FAIL stall_next: got ok=%0d type=%b byte=%h expected 10/10", ok, t, b);
    end
    get_tx(ok, t, b);
    get_tx(ok, t, b);
    get_tx(ok, t, b);
    send_ping();
    send_byte(8'h03, 1'b0);
    send_ping();
    run_ticks(GAP_UI - 1, sawRsp, sawTx);
    pulse_tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_rdata !== 8'h00) begin
      failures++;
      $display("[TB] FAIL nack_rsp: got v=%b status=%b rdata=%h expected v=1 status=01 rdata=00",
               rsp_valid, rsp_status, rsp_rdata);
    end
    run_ticks(4, sawRsp, sawTx);
    checks++;
    if (sawTx || sawRsp || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL nack_no_retry: got tx=%0d rsp=%0d ready=%b expected 0 0 1",
               sawTx, sawRsp, req_ready);
    end
  endtask

  task automatic test_read();
    bit ok, sawRsp, sawTx;
    logic [1:0] t;
    logic [7:0] b;
    logic [1:0] expT [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic [7:0] expB [4] = '{8'h00, 8'h0C, 8'h04, 8'hE2};
    request(1'b0, 8'h04, 8'h00);
    for (int i = 0; i < 4; i++) begin
      get_tx(ok, t, b);
      checks++;
      if (!ok || t !== expT[i] || b !== expB[i]) begin
        failures++;
        $display("[TB] FAIL read_sym%0d: got ok=%0d type=%b byte=%h expected type=%b byte=%h",
                 i, ok, t, b, expT[i], expB[i]);
      end
      if (i == 0) send_ping();
    end
    get_tx(ok, t, b);
    send_ping();
    send_byte(8'h08, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h1A, 1'b0);
    send_ping();
    run_ticks(GAP_UI - 1, sawRsp, sawTx);
    checks++;
    if (sawRsp) begin
      failures++;
      $display("[TB] FAIL read_gap: got early rsp_valid expected none");
    end
    pulse_tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 8'h41) begin
      failures++;
      $display("[TB] FAIL read_rsp: got v=%b status=%b rdata=%h expected v=1 status=00 rdata=41",
               rsp_valid, rsp_status, rsp_rdata);
    end
    cyc();
  endtask

  task automatic test_crc_retry();
    bit ok, sawRsp, sawTx;
    request(1'b0, 8'h04, 8'h00);
    master_phase(3, ok);
    send_byte(8'h08, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h55, 1'b0);
    send_ping();
    run_ticks(GAP_UI - 1, sawRsp, sawTx);
    pulse_tick();
    checks++;
    if (sawRsp || rsp_valid !== 1'b0 || phy_tx_valid !== 1'b1 || phy_tx_type !== 2'b00) begin
      failures++;
      $display("[TB] FAIL crc_retry_start: got rsp=%0d/%b txv=%b type=%b expected no rsp, ping",
               sawRsp, rsp_valid, phy_tx_valid, phy_tx_type);
    end
    master_phase(3, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL crc_retry_frame: got ok=0 expected ok=1");
    end
    send_byte(8'h08, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h1A, 1'b0);
    send_ping();
    run_ticks(GAP_UI - 1, sawRsp, sawTx);
    pulse_tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 8'h41) begin
      failures++;
      $display("[TB] FAIL crc_retry_rsp: got v=%b status=%b rdata=%h expected v=1 status=00 rdata=41",
               rsp_valid, rsp_status, rsp_rdata);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    bit ok, sawRsp, sawTx;
    request(1'b0, 8'h04, 8'h00);
    master_phase(3, ok);
    send_byte(8'h08, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid, phy_tx_valid} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL rstmid_flags: got ready/busy/rspv/txv=%b expected 1000",
               {req_ready, busy, rsp_valid, phy_tx_valid});
    end
    checks++;
    if ({rsp_status, rsp_rdata, phy_tx_type, phy_tx_byte} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL rstmid_values: got status=%b rdata=%h type=%b byte=%h expected all zero",
               rsp_status, rsp_rdata, phy_tx_type, phy_tx_byte);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_release: got ready=%b busy=%b expected 1 0", req_ready, busy);
    end
    send_byte(8'h41, 1'b0);
    send_byte(8'h1A, 1'b0);
    send_ping();
    run_ticks(GAP_UI + 2, sawRsp, sawTx);
    checks++;
    if (sawRsp || sawTx || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_abandoned: got rsp=%0d tx=%0d ready=%b expected 0 0 1",
               sawRsp, sawTx, req_ready);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    ui_tick      = 1'b0;
    req_valid    = 1'b0;
    req_wr       = 1'b0;
    req_addr     = 8'h00;
    req_wdata    = 8'h00;
    phy_tx_ready = 1'b1;
    phy_rx_ping  = 1'b0;
    phy_rx_valid = 1'b0;
    phy_rx_byte  = 8'h00;
    phy_rx_err   = 1'b0;
    cyc();
    test_reset();
    test_write();
    test_timeout();
    test_nack_stall();
    test_read();
    test_crc_retry();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
